// File: rtl/softmax_tile_feeder.sv
// Feeds softmax_vec: packs a scalar element stream into tiles, issues the start pulse,
// and waits for softmax completion before accepting the next row.
module softmax_tile_feeder #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TOTAL_ELEMENTS = 64,
    parameter int unsigned TILE_SIZE      = 8,
    parameter int unsigned DONE_TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [WIDTH-1:0]             elem_in,
    input  logic                         elem_valid,
    output logic                         elem_ready,
    output logic                         sm_start,
    output logic [TILE_SIZE*WIDTH-1:0]   tile_out,
    output logic                         tile_valid,
    input  logic                         sm_done,
    output logic                         row_done,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [15:0]                  rows_sent
);

    localparam int unsigned TILE_W = TILE_SIZE * WIDTH;
    localparam int unsigned CNT_W  = $clog2(TOTAL_ELEMENTS + 1);
    localparam int unsigned SLOT_W = $clog2(TILE_SIZE);
    localparam int unsigned WAIT_W = $clog2(DONE_TIMEOUT + 1);

    if ((TOTAL_ELEMENTS % TILE_SIZE) != 0 || TILE_SIZE < 2) begin : g_param_check
        $error("softmax_tile_feeder: TOTAL_ELEMENTS must be a multiple of TILE_SIZE and TILE_SIZE >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    elem_cnt;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [TILE_W-1:0]   pack_q;
    logic [TILE_W-1:0]   pack_next_c;
    logic [CNT_W-1:0]    elem_cnt_inc_c;
    logic                elem_accept_c;
    logic                tile_last_c;
    logic                wait_expired_c;

    assign elem_accept_c  = elem_valid && elem_ready;
    assign elem_cnt_inc_c = elem_cnt + CNT_W'(1);
    assign tile_last_c    = (slot_cnt == SLOT_W'(TILE_SIZE - 1));
    assign wait_expired_c = (wait_cnt == WAIT_W'(DONE_TIMEOUT - 1));

    // Element k of a tile lands in chunk k counted from the MS end.
    always_comb begin
        pack_next_c = pack_q;
        pack_next_c[(TILE_SIZE - 1 - 32'(slot_cnt)) * WIDTH +: WIDTH] = elem_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            elem_cnt    <= '0;
            slot_cnt    <= '0;
            wait_cnt    <= '0;
            pack_q      <= '0;
            elem_ready  <= 1'b0;
            sm_start    <= 1'b0;
            tile_out    <= '0;
            tile_valid  <= 1'b0;
            row_done    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rows_sent   <= '0;
        end else if (en) begin
            sm_start   <= 1'b0;
            tile_valid <= 1'b0;
            row_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    elem_ready <= 1'b0;
                    if (elem_valid) begin
                        state    <= S_START;
                        sm_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                // Start pulse is visible here; streaming opens on the next cycle.
                S_START: begin
                    state      <= S_STREAM;
                    elem_ready <= 1'b1;
                end
                S_STREAM: begin
                    if (elem_accept_c) begin
                        elem_cnt   <= elem_cnt_inc_c;
                        elem_ready <= (elem_cnt_inc_c < CNT_W'(TOTAL_ELEMENTS));
                        if (tile_last_c) begin
                            tile_out   <= pack_next_c;
                            tile_valid <= 1'b1;
                            pack_q     <= '0;
                            slot_cnt   <= '0;
                        end else begin
                            pack_q   <= pack_next_c;
                            slot_cnt <= slot_cnt + SLOT_W'(1);
                        end
                    end else if (elem_cnt == CNT_W'(TOTAL_ELEMENTS)) begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    elem_ready <= 1'b0;
                    // sm_done takes priority over an expiring wait counter.
                    if (sm_done) begin
                        row_done  <= 1'b1;
                        rows_sent <= rows_sent + 16'd1;
                        elem_cnt  <= '0;
                        slot_cnt  <= '0;
                        wait_cnt  <= '0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (wait_expired_c) begin
                        timeout_err <= 1'b1;
                        elem_cnt    <= '0;
                        slot_cnt    <= '0;
                        wait_cnt    <= '0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_tile_feeder.sv
// Randomized bench for softmax_tile_feeder: rows of elements checked against tiles
// rebuilt from the accepted element list, plus start/done/timeout/enable/reset behaviour.
module tb_softmax_tile_feeder;

    localparam int unsigned W   = 32;
    localparam int unsigned TOT = 64;
    localparam int unsigned TS  = 8;
    localparam int unsigned NT  = TOT / TS;
    localparam int unsigned DT  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [W-1:0]      elem_in;
    logic              elem_valid;
    logic              elem_ready;
    logic              sm_start;
    logic [TS*W-1:0]   tile_out;
    logic              tile_valid;
    logic              sm_done;
    logic              row_done;
    logic              busy;
    logic              timeout_err;
    logic [15:0]       rows_sent;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_rows = 0;
    bit exp_timeout = 1'b0;
    logic [W-1:0] row_elems [TOT];

    softmax_tile_feeder #(
        .WIDTH(W), .TOTAL_ELEMENTS(TOT), .TILE_SIZE(TS), .DONE_TIMEOUT(DT)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .elem_in(elem_in), .elem_valid(elem_valid), .elem_ready(elem_ready),
        .sm_start(sm_start), .tile_out(tile_out), .tile_valid(tile_valid),
        .sm_done(sm_done), .row_done(row_done), .busy(busy),
        .timeout_err(timeout_err), .rows_sent(rows_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Tile j is elements j*TS .. j*TS+TS-1 concatenated, first element most significant.
    function automatic logic [TS*W-1:0] expected_tile(input int j);
        logic [TS*W-1:0] t;
        t = '0;
        for (int k = 0; k < TS; k++) t = {t[TS*W-W-1:0], row_elems[j*TS + k]};
        return t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   256'(elem_ready), 256'(0));
        check({tag, "_start"},   256'(sm_start), 256'(0));
        check({tag, "_tile"},    256'(tile_out), 256'(0));
        check({tag, "_tvalid"},  256'(tile_valid), 256'(0));
        check({tag, "_rowdone"}, 256'(row_done), 256'(0));
        check({tag, "_busy"},    256'(busy), 256'(0));
        check({tag, "_timeout"}, 256'(timeout_err), 256'(0));
        check({tag, "_rows"},    256'(rows_sent), 256'(0));
    endtask

    // One row: stream TOT elements with random gaps, then sm_done after done_delay
    // cycles (do_done=0 lets the wait time out). abort_after>0 resets mid-row.
    task automatic run_row(input int gap_pct, input bit seq_data, input int seq_base,
                           input bit do_done, input int done_delay,
                           input int freeze_tile, input int abort_after);
        int sent = 0;
        int tiles_seen = 0;
        int last_tile_cyc = 0;
        int freeze_left = 0;
        bit acc;
        bit prev_tv;
        logic [TS*W-1:0] prev_tile;

        for (int i = 0; i < TOT; i++)
            row_elems[i] = seq_data ? W'(seq_base + i) : W'($urandom);

        en = 1'b1; sm_done = 1'b0; elem_valid = 1'b1; elem_in = row_elems[0];
        tick();
        check("start_pulse", 256'(sm_start), 256'(1));
        check("start_busy", 256'(busy), 256'(1));
        check("start_no_ready", 256'(elem_ready), 256'(0));
        check("start_timeout_sticky", 256'(timeout_err), 256'(exp_timeout));

        for (int guard = 0; tiles_seen < NT; guard++) begin
            if (guard > 2000) begin
                check("stream_bound", 256'(0), 256'(1));
                break;
            end
            en = (freeze_left == 0);
            if (freeze_left > 0) freeze_left--;
            elem_valid = (sent < TOT) && ($urandom_range(0, 99) >= gap_pct);
            elem_in    = elem_valid ? row_elems[sent] : W'($urandom);
            sm_done    = ($urandom_range(0, 3) == 0);
            acc        = en && elem_valid && elem_ready;
            prev_tv    = tile_valid;
            prev_tile  = tile_out;
            if (acc) sent++;
            tick();
            check("stream_start_low", 256'(sm_start), 256'(0));
            check("stream_rowdone_low", 256'(row_done), 256'(0));
            check("stream_ready", 256'(elem_ready), 256'(sent < TOT));
            if (!en) begin
                check("freeze_tvalid", 256'(tile_valid), 256'(prev_tv));
                check("freeze_tile", 256'(tile_out), 256'(prev_tile));
            end else begin
                check("tile_valid", 256'(tile_valid), 256'(acc && (sent % TS == 0)));
                if (acc && (sent % TS == 0)) begin
                    check("tile_data", 256'(tile_out), 256'(expected_tile(tiles_seen)));
                    if (gap_pct == 0 && freeze_tile < 0 && tiles_seen > 0)
                        check("tile_spacing", 256'(cyc - last_tile_cyc), 256'(TS));
                    last_tile_cyc = cyc;
                    if (tiles_seen == freeze_tile) freeze_left = 3;
                    tiles_seen++;
                end
            end
            if (abort_after > 0 && sent == abort_after) begin
                en = 1'b1; rst = 1'b1; elem_valid = 1'b1;
                tick();
                rst = 1'b0;
                exp_rows = 0;
                exp_timeout = 1'b0;
                check_reset_outputs("abort");
                return;
            end
        end

        elem_valid = 1'b0;
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            sm_done = do_done && (i == done_delay);
            tick();
            check("wait_ready_low", 256'(elem_ready), 256'(0));
            check("wait_tvalid_low", 256'(tile_valid), 256'(0));
            if (do_done && i == done_delay) begin
                exp_rows++;
                check("row_done", 256'(row_done), 256'(1));
                check("rows_sent", 256'(rows_sent), 256'(exp_rows & 16'hFFFF));
                check("done_busy", 256'(busy), 256'(0));
                check("done_timeout", 256'(timeout_err), 256'(exp_timeout));
                break;
            end
            check("wait_rowdone_low", 256'(row_done), 256'(0));
            if (!do_done && i == DT + 1) begin
                exp_timeout = 1'b1;
                check("timeout_set", 256'(timeout_err), 256'(1));
                check("timeout_idle", 256'(busy), 256'(0));
                check("timeout_rows", 256'(rows_sent), 256'(exp_rows));
                break;
            end
            check("wait_timeout", 256'(timeout_err), 256'(exp_timeout));
            check("wait_busy", 256'(busy), 256'(1));
        end
        sm_done = 1'b0;

        if (!do_done) begin
            // sm_done arriving in S_IDLE must be ignored; the error stays sticky.
            for (int i = 0; i < 3; i++) begin
                sm_done = 1'b1;
                tick();
                check("late_done_ignored", 256'(row_done), 256'(0));
                check("idle_start_low", 256'(sm_start), 256'(0));
                check("timeout_sticky", 256'(timeout_err), 256'(1));
                check("idle_busy", 256'(busy), 256'(0));
            end
            sm_done = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; elem_valid = 1'b0; elem_in = '0; sm_done = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        elem_valid = 1'b0;
        tick();
        check("idle_no_start", 256'(sm_start), 256'(0));

        run_row(0,  1'b1, 0,    1'b1, 5,  -1, 0);   // ordered data, no gaps
        run_row(50, 1'b1, 0,    1'b1, 5,  -1, 0);   // same data, 50% gaps, back-to-back
        run_row(30, 1'b0, 0,    1'b1, 17, -1, 0);   // sm_done coincides with timeout
        run_row(0,  1'b0, 0,    1'b1, 5,  2,  0);   // enable freeze on a tile cycle
        run_row(20, 1'b0, 0,    1'b0, 0,  -1, 0);   // no sm_done -> timeout
        run_row(10, 1'b0, 0,    1'b1, 3,  -1, 0);   // row after timeout, error sticky
        run_row(0,  1'b1, 1000, 1'b1, 5,  -1, 13);  // reset after 13 elements
        run_row(0,  1'b1, 0,    1'b1, 5,  -1, 0);   // fresh row, no residue
        run_row(40, 1'b0, 0,    1'b1, 2,  -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
